// File: rtl/mcu_user_arbiter.sv
// Two-requester arbiter sharing one memory-controller user port between the
// i-cache and d-cache memory sides. Serialises whole transactions.
`timescale 1ns/1ps
module mcu_user_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned D_PRIORITY = 0,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              MCU_CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_datain,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_dataout,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_datain,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_dataout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datain,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              gnt_d,
  output logic              busy
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic               last_d, last_d_nx;
  logic [CNT_W-1:0]   starve, starve_nx;
  logic               mem_req_nx, mem_we_nx, i_ack_nx, d_ack_nx, gnt_d_nx, busy_nx;
  logic [ADDR_W-1:0]  mem_addr_nx;
  logic [DATA_W-1:0]  mem_datain_nx, i_dataout_nx, d_dataout_nx;
  logic               cand_i, cand_d, win_d;

  // Next-state, grant and registered-output computation.
  always_comb begin
    state_nx      = state;
    last_d_nx     = last_d;
    starve_nx     = starve;
    mem_req_nx    = mem_req;
    mem_we_nx     = mem_we;
    mem_addr_nx   = mem_addr;
    mem_datain_nx = mem_datain;
    i_ack_nx      = 1'b0;
    d_ack_nx      = 1'b0;
    i_dataout_nx  = i_dataout;
    d_dataout_nx  = d_dataout;
    gnt_d_nx      = gnt_d;
    cand_i        = 1'b0;
    cand_d        = 1'b0;
    win_d         = 1'b0;

    case (state)
      IDLE: begin
        cand_i = i_req;
        cand_d = d_req;
      end
      BUSY: begin
        if (mem_ack) begin
          mem_req_nx = 1'b0;
          last_d_nx  = gnt_d;
          state_nx   = ACK;
          if (gnt_d) begin
            d_ack_nx     = 1'b1;
            d_dataout_nx = mem_dataout;
          end else begin
            i_ack_nx     = 1'b1;
            i_dataout_nx = mem_dataout;
          end
        end
      end
      ACK: state_nx = GAP;
      GAP: begin
        cand_i = i_req & last_d;
        cand_d = d_req & ~last_d;
        // In d-priority mode a still-pending d re-wins via IDLE unless i is starved.
        if ((D_PRIORITY != 0) && last_d && d_req && (starve != LIM)) cand_i = 1'b0;
        if (!(cand_i || cand_d)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (cand_i && cand_d) win_d = (D_PRIORITY != 0) ? (starve != LIM) : ~last_d;
    else                  win_d = cand_d;

    if (cand_i || cand_d) begin
      state_nx      = BUSY;
      mem_req_nx    = 1'b1;
      gnt_d_nx      = win_d;
      mem_we_nx     = win_d ? d_we     : i_we;
      mem_addr_nx   = win_d ? d_addr   : i_addr;
      mem_datain_nx = win_d ? d_datain : i_datain;
      if (win_d && i_req) starve_nx = (starve == LIM) ? starve : starve + CNT_W'(1);
      else                starve_nx = '0;
    end

    busy_nx = (state_nx != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge MCU_CLK) begin
    if (!RST) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      starve     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_dataout  <= '0;
      d_dataout  <= '0;
      gnt_d      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      last_d     <= last_d_nx;
      starve     <= starve_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_datain <= mem_datain_nx;
      i_ack      <= i_ack_nx;
      d_ack      <= d_ack_nx;
      i_dataout  <= i_dataout_nx;
      d_dataout  <= d_dataout_nx;
      gnt_d      <= gnt_d_nx;
      busy       <= busy_nx;
    end
  end

endmodule
